// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle unsigned MULTU / DIVU sequencer.
// It borrows the shared combinational ALU for one add or subtract per cycle
// and deposits the 64-bit outcome in HI/LO for the CPU's mfhi/mflo path.
module alu_muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_rs,
   output logic [WIDTH-1:0] alu_rt,
   input  logic [WIDTH-1:0] alu_rd
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ra, rb, acc, mq;
   logic [WIDTH-1:0] acc_d, mq_d;
   logic [4:0]       cnt;
   logic             mode;

   logic             msb;
   logic             c;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] sum;

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: accept start only when idle or finishing, 32 RUN cycles.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt == 5'd31) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // One shift-add (MULTU) or restoring-subtract (DIVU) step through the ALU.
   always_comb begin
      alu_op = 4'b0000;
      alu_rs = '0;
      alu_rt = '0;
      acc_d  = acc;
      mq_d   = mq;
      msb    = acc[WIDTH-1];
      sh     = {acc[WIDTH-2:0], mq[WIDTH-1]};
      sum    = acc;
      c      = 1'b0;
      if (state_q == RUN) begin
         if (!mode) begin
            alu_op = 4'b0011;
            alu_rs = acc;
            alu_rt = ra;
            if (mq[0]) begin
               sum = alu_rd;
               // Carry out of the 32-bit add recovered by wrap-around compare.
               c   = (alu_rd < acc);
            end
            acc_d = {c, sum[WIDTH-1:1]};
            mq_d  = {sum[0], mq[WIDTH-1:1]};
         end else begin
            alu_op = 4'b0110;
            alu_rs = sh;
            alu_rt = rb;
            // msb set means the 33-bit partial remainder already exceeds rb.
            if (msb || (sh >= rb)) begin
               acc_d = alu_rd;
               mq_d  = {mq[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = sh;
               mq_d  = {mq[WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   // Operand latch, iteration registers and HI/LO result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra   <= '0;
         rb   <= '0;
         acc  <= '0;
         mq   <= '0;
         cnt  <= '0;
         mode <= 1'b0;
         hi   <= '0;
         lo   <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  ra   <= a;
                  rb   <= b;
                  mode <= op_div;
                  acc  <= '0;
                  mq   <= op_div ? a : b;
                  cnt  <= '0;
               end
            end
            RUN: begin
               acc <= acc_d;
               mq  <= mq_d;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  hi <= acc_d;
                  lo <= mq_d;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq: directed boundary cases plus random
// MULTU/DIVU operations against a plain-arithmetic reference model.
module tb_alu_muldiv_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        op_div;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;
   logic [3:0]  alu_op;
   logic [31:0] alu_rs, alu_rt, alu_rd;

   int n_vec = 0;
   int n_err = 0;

   alu_muldiv_seq #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_div (op_div),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo),
      .alu_op (alu_op),
      .alu_rs (alu_rs),
      .alu_rt (alu_rt),
      .alu_rd (alu_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared combinational ALU as seen by the sequencer.
   always_comb begin
      case (alu_op)
         4'b0011: alu_rd = alu_rs + alu_rt;
         4'b0110: alu_rd = alu_rs - alu_rt;
         default: alu_rd = alu_rt;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {hi, lo} from the architectural definition of MULTU / DIVU.
   function automatic logic [63:0] model(input logic op, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      if (!op) begin
         p = {32'd0, x} * {32'd0, y};
         return p;
      end
      if (y == 32'd0) return {x, 32'hFFFFFFFF};
      return {x % y, x / y};
   endfunction

   // Launch one operation from the current time, follow it to done, check it.
   // poke >= 1 applies a conflicting start during that RUN cycle.
   task automatic run_op(input string tag, input logic op, input logic [31:0] x,
                         input logic [31:0] y, input int poke);
      int          n;
      bit          busy_ok;
      logic [63:0] exp;
      exp    = model(op, x, y);
      start  = 1'b1;
      op_div = op;
      a      = x;
      b      = y;
      @(posedge clk); #1;
      n       = 1;
      busy_ok = 1'b1;
      start   = 1'b0;
      while (!done && n < 40) begin
         if (!busy) busy_ok = 1'b0;
         if (n == poke) begin
            start  = 1'b1;
            op_div = ~op;
            a      = 32'd9;
            b      = 32'd2;
         end else begin
            start  = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      chk({tag, ".latency"}, 64'(n), 64'd33);
      chk({tag, ".busy_run"}, 64'(busy_ok), 64'd1);
      chk({tag, ".busy_done"}, 64'(busy), 64'd0);
      chk({tag, ".hilo"}, {hi, lo}, exp);
   endtask

   initial begin
      int          n;
      bit          seen;
      logic        rop;
      logic [31:0] rx, ry;

      rst_n  = 1'b0;
      start  = 1'b0;
      op_div = 1'b0;
      a      = '0;
      b      = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.outs", {busy, done, hi, lo, alu_op, alu_rs, alu_rt}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("multu_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      chk("multu_max.hi", 64'(hi), 64'hFFFFFFFE);
      chk("multu_max.lo", 64'(lo), 64'h00000001);
      @(posedge clk); #1;
      chk("multu_max.single_done", {busy, done}, 64'd0);
      chk("idle.alu_drive", {alu_op, alu_rs, alu_rt}, '0);

      run_op("divu_100_7", 1'b1, 32'd100, 32'd7, 0);
      chk("divu_100_7.lo", 64'(lo), 64'd14);
      chk("divu_100_7.hi", 64'(hi), 64'd2);
      @(negedge clk);
      run_op("divu_5_9", 1'b1, 32'd5, 32'd9, 0);
      @(negedge clk);
      run_op("divu_msb", 1'b1, 32'hFFFFFFFF, 32'h80000000, 0);
      chk("divu_msb.lo", 64'(lo), 64'd1);
      chk("divu_msb.hi", 64'(hi), 64'h7FFFFFFF);
      @(negedge clk);
      run_op("divu_by0", 1'b1, 32'h12345678, 32'd0, 0);
      chk("divu_by0.lo", 64'(lo), 64'hFFFFFFFF);
      chk("divu_by0.hi", 64'(hi), 64'h12345678);
      @(negedge clk);

      run_op("ignore_start", 1'b0, 32'd3, 32'd5, 10);
      chk("ignore_start.lo", 64'(lo), 64'd15);
      @(posedge clk); #1;
      chk("ignore_start.single_done", {busy, done}, 64'd0);
      @(negedge clk);

      // Back-to-back: second start presented in the DONE cycle.
      run_op("b2b_first", 1'b0, 32'd123456, 32'd789, 0);
      run_op("b2b_second", 1'b1, 32'd1000000, 32'd33, 0);
      @(negedge clk);

      // Reset mid-RUN aborts immediately and no done follows.
      start  = 1'b1;
      op_div = 1'b0;
      a      = 32'hDEADBEEF;
      b      = 32'h1234;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrun_reset.outs", {busy, done, hi, lo}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1'b1;
      end
      chk("midrun_reset.no_done", 64'(seen), 64'd0);
      @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         rop = $urandom_range(0, 1);
         rx  = $urandom;
         case ($urandom_range(0, 3))
            0:       ry = 32'd0;
            1:       ry = $urandom_range(1, 255);
            default: ry = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), rop, rx, ry, 0);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
